// File: rtl/s2a_controller_if.sv
// AXI3 write-address/data/response channel bundle between the s2a controller and the OCM port.
// The controller is the master; the OCM side (or a bench responder) is the slave.
interface s2a_controller_if;
    logic [31:0] AXI_awaddr;
    logic [3:0]  AXI_awlen;
    logic        AXI_awvalid;
    logic        AXI_awready;
    logic        AXI_wvalid;
    logic        AXI_wready;
    logic        AXI_wlast;
    logic        AXI_bvalid;
    logic        AXI_bready;
    logic [1:0]  AXI_bresp;

    modport master (
        output AXI_awaddr, AXI_awlen, AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready,
        input  AXI_awready, AXI_wready, AXI_bvalid, AXI_bresp
    );

    modport slave (
        input  AXI_awaddr, AXI_awlen, AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready,
        output AXI_awready, AXI_wready, AXI_bvalid, AXI_bresp
    );
endinterface

// File: rtl/s2a_controller.sv
// Stream-to-AXI write controller: fills a 32-word ping-pong buffer on Sclk and writes each
// completed 16-word half to OCM as one 16-beat AXI3 INCR burst on AXI_clk.
//
// state  | meaning
// IDLE   | waiting for a half-done event from the stream side
// ADDR   | AW channel presented, waiting for awready
// DATA   | issuing 16 W beats, buffer read address advances per accepted beat
// RESP   | waiting for the B response
module s2a_controller #(
    parameter logic [31:0] ocm_haddr = 32'hfffc0000,
    parameter int          ocm_width = 16
) (
    input  logic        rst,
    input  logic        Sclk,
    input  logic        sync,
    input  logic        Ien,
    output logic [4:0]  Iaddr,
    output logic [31:0] s2a_cnt,
    input  logic        AXI_clk,
    s2a_controller_if.master axi,
    output logic [4:0]  s2a_addr,
    output logic        s2a_rd,
    output logic        s2a_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    // ---------------- Sclk domain ----------------
    logic [35:0] r_cnt;
    logic        r_toggle;
    logic [31:0] r_blk_addr;
    logic        r_blk_half;

    logic [31:0] w_win_mask;
    logic [31:0] w_blk_off;

    assign w_win_mask = 32'((64'd1 << ocm_width) - 64'd1);
    // Block index times 64 bytes, folded into the OCM window.
    assign w_blk_off  = {r_cnt[29:4], 6'b0} & w_win_mask;

    always_ff @(posedge Sclk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_toggle   <= 1'b0;
            r_blk_addr <= '0;
            r_blk_half <= 1'b0;
        end else if (sync) begin
            r_cnt <= '0;
        end else if (Ien) begin
            r_cnt <= r_cnt + 36'd1;
            if (r_cnt[3:0] == 4'hf) begin
                r_toggle   <= ~r_toggle;
                r_blk_addr <= ocm_haddr + w_blk_off;
                r_blk_half <= r_cnt[4];
            end
        end
    end

    assign Iaddr   = r_cnt[4:0];
    assign s2a_cnt = r_cnt[35:4];

    // ---------------- AXI_clk domain ----------------
    // blk_addr/blk_half are held for a full half-fill after each toggle flip, so they are
    // stable long before the synchronised toggle edge reaches the FSM.
    logic r_tog_meta;
    logic r_tog_sync;
    logic r_tog_prev;
    logic w_start;

    always_ff @(posedge AXI_clk or posedge rst) begin
        if (rst) begin
            r_tog_meta <= 1'b0;
            r_tog_sync <= 1'b0;
            r_tog_prev <= 1'b0;
        end else begin
            r_tog_meta <= r_toggle;
            r_tog_sync <= r_tog_meta;
            r_tog_prev <= r_tog_sync;
        end
    end

    assign w_start = r_tog_sync ^ r_tog_prev;

    state_t      r_state;
    logic [31:0] r_awaddr;
    logic [4:0]  r_s2a_addr;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_wlast;
    logic        r_bready;
    logic        r_err;

    state_t      w_state_nx;
    logic [31:0] w_awaddr_nx;
    logic [4:0]  w_s2a_addr_nx;
    logic        w_awvalid_nx;
    logic        w_wvalid_nx;
    logic        w_wlast_nx;
    logic        w_bready_nx;
    logic        w_err_nx;
    logic        w_beat;

    assign w_beat = r_wvalid & axi.AXI_wready;

    always_ff @(posedge AXI_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_awaddr   <= '0;
            r_s2a_addr <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_wlast    <= 1'b0;
            r_bready   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_awaddr   <= w_awaddr_nx;
            r_s2a_addr <= w_s2a_addr_nx;
            r_awvalid  <= w_awvalid_nx;
            r_wvalid   <= w_wvalid_nx;
            r_wlast    <= w_wlast_nx;
            r_bready   <= w_bready_nx;
            r_err      <= w_err_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_awaddr_nx   = r_awaddr;
        w_s2a_addr_nx = r_s2a_addr;
        w_awvalid_nx  = r_awvalid;
        w_wvalid_nx   = r_wvalid;
        w_wlast_nx    = r_wlast;
        w_bready_nx   = r_bready;
        w_err_nx      = r_err;

        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_awaddr_nx   = r_blk_addr;
                    w_s2a_addr_nx = {r_blk_half, 4'h0};
                    w_awvalid_nx  = 1'b1;
                    w_state_nx    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (r_awvalid && axi.AXI_awready) begin
                    w_awvalid_nx = 1'b0;
                    w_wvalid_nx  = 1'b1;
                    w_state_nx   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_beat) begin
                    w_s2a_addr_nx[3:0] = r_s2a_addr[3:0] + 4'd1;
                    w_wlast_nx         = (r_s2a_addr[3:0] == 4'he);
                    if (r_s2a_addr[3:0] == 4'hf) begin
                        w_wvalid_nx = 1'b0;
                        w_wlast_nx  = 1'b0;
                        w_bready_nx = 1'b1;
                        w_state_nx  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (axi.AXI_bvalid && r_bready) begin
                    w_bready_nx = 1'b0;
                    if (axi.AXI_bresp != 2'b00) begin
                        w_err_nx = 1'b1;
                    end
                    w_state_nx = ST_IDLE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        // A half completing while a burst is still in flight is dropped and flagged.
        if (w_start && (r_state != ST_IDLE)) begin
            w_err_nx = 1'b1;
        end
    end

    assign axi.AXI_awaddr  = r_awaddr;
    assign axi.AXI_awlen   = 4'hf;
    assign axi.AXI_awvalid = r_awvalid;
    assign axi.AXI_wvalid  = r_wvalid;
    assign axi.AXI_wlast   = r_wlast;
    assign axi.AXI_bready  = r_bready;
    assign s2a_addr        = r_s2a_addr;
    assign s2a_rd          = w_beat;
    assign s2a_err         = r_err;

endmodule
